// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
// Reset vector, fetch FSM states, instruction width.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_3000;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_inc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory port and IF/ID output bundle.
// master = fetch sequencer, slave = memory + IF/ID side.
interface fetch_sequencer_if;
  import mips_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;
  logic [31:0]        if_pc4;

  modport master (
    output imem_req, imem_addr,
    output if_valid, if_instr,
    output if_pc, if_pc4,
    input  imem_ready, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    input  if_valid, if_instr,
    input  if_pc, if_pc4,
    output imem_ready, imem_rdata
  );

endinterface

// File: rtl/fetch_buf.sv
// IF/ID-facing register holding one fetched instruction.
// Load has priority over clear; otherwise contents hold.
module fetch_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_pc4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_instr <= NOP;
      o_pc    <= 32'h0;
      o_pc4   <= 32'h0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_instr <= i_instr;
      o_pc    <= i_pc;
      o_pc4   <= pc_inc(i_pc);
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction-fetch sequencer with delay-slot
// aware redirects and a wait-state tolerant memory port.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_d,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  fetch_sequencer_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nx;
  logic [31:0]  r_next_pc;
  logic [31:0]  r_pend_pc;
  logic         r_pend_v;
  logic         w_gate;
  logic         w_req;
  logic         w_acc;
  logic         w_direct;

  assign w_gate = !bus.if_valid || !stall_d;
  assign w_acc  = w_req && bus.imem_ready;

  // A waiting request must keep its address, so a redirect
  // that lands mid-wait is parked in pend until acceptance.
  assign w_direct = w_acc || (bus.if_valid && !w_req);

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_next_pc;

  always_comb begin
    w_state_nx = r_state;
    w_req      = 1'b0;
    unique case (r_state)
      IDLE: w_state_nx = REQ;
      REQ, HOLD: begin
        w_req      = w_gate;
        w_state_nx = w_gate ? REQ : HOLD;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_next_pc <= RESET_PC;
      r_pend_v  <= 1'b0;
      r_pend_pc <= 32'h0;
    end else begin
      r_state <= w_state_nx;
      if (redir_valid && w_direct) begin
        r_next_pc <= redir_pc;
        r_pend_v  <= 1'b0;
      end else if (redir_valid) begin
        r_pend_v  <= 1'b1;
        r_pend_pc <= redir_pc;
      end else if (w_acc) begin
        r_next_pc <= r_pend_v ? r_pend_pc
                              : pc_inc(r_next_pc);
        r_pend_v  <= 1'b0;
      end
    end
  end

  // Branch in a delay slot is architecturally undefined.
  always_ff @(posedge clk) begin
    if (reset_n && redir_valid)
      assert (!r_pend_v);
  end

  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_load  (w_acc),
    .i_clear (!stall_d),
    .i_instr (bus.imem_rdata),
    .i_pc    (bus.imem_addr),
    .o_valid (bus.if_valid),
    .o_instr (bus.if_instr),
    .o_pc    (bus.if_pc),
    .o_pc4   (bus.if_pc4)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
// Memory returns addr ^ K so instr/pc pairing is checkable.
module tb_fetch_sequencer;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        reset_n;
  logic        stall_d;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        r_ready;
  int          checks;
  int          errors;

  fetch_sequencer_if bus();

  assign bus.imem_ready = r_ready;
  assign bus.imem_rdata = bus.imem_addr ^ K;

  fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_d     (stall_d),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    stall_d     = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    r_ready     = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: got %b want 0", bus.imem_req);
    end
    checks++;
    if (bus.imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL rst_addr: got %h want 3000", bus.imem_addr);
    end
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", bus.if_valid);
    end
    checks++;
    if (bus.if_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_instr: got %h want 0", bus.if_instr);
    end
    checks++;
    if (bus.if_pc !== 32'h0 || bus.if_pc4 !== 32'h0) begin
      errors++;
      $display("FAIL rst_pc: got %h/%h want 0/0",
               bus.if_pc, bus.if_pc4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %b want 0", bus.imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      a = 32'h3000 + 32'(4 * i);
      p = a - 32'd4;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin
        errors++;
        $display("FAIL seq_addr: got %b/%h want 1/%h",
                 bus.imem_req, bus.imem_addr, a);
      end
      checks++;
      if (i == 0 && bus.if_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_first_valid: got %b want 0",
                 bus.if_valid);
      end else if (i > 0 && (bus.if_valid !== 1'b1 ||
                   bus.if_pc !== p ||
                   bus.if_pc4 !== a ||
                   bus.if_instr !== (p ^ K))) begin
        errors++;
        $display("FAIL seq_buf: got %b %h %h %h want 1 %h %h %h",
                 bus.if_valid, bus.if_pc, bus.if_pc4,
                 bus.if_instr, p, a, p ^ K);
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    r_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) r_ready = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
        errors++;
        $display("FAIL wait_hold: cyc %0d got %b/%h want 1/3004",
                 i, bus.imem_req, bus.imem_addr);
      end
      if (i > 0) begin
        checks++;
        if (bus.if_valid !== 1'b0) begin
          errors++;
          $display("FAIL wait_valid: cyc %0d got %b want 0",
                   i, bus.if_valid);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.imem_addr !== 32'h3008 || bus.if_pc !== 32'h3004 ||
        bus.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_after: got %h/%h/%b want 3008/3004/1",
               bus.imem_addr, bus.if_pc, bus.if_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      stall_d = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || bus.if_pc !== 32'h3008 ||
          bus.if_valid !== 1'b1 ||
          bus.if_instr !== (32'h3008 ^ K)) begin
        errors++;
        $display("FAIL stall_hold: cyc %0d got %b/%h/%b want 0/3008/1",
                 i, bus.imem_req, bus.if_pc, bus.if_valid);
      end
      @(negedge clk);
    end
    stall_d = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300C ||
        bus.if_pc !== 32'h3008) begin
      errors++;
      $display("FAIL stall_release: got %b/%h/%h want 1/300c/3008",
               bus.imem_req, bus.imem_addr, bus.if_pc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.if_pc !== 32'h300C || bus.imem_addr !== 32'h3010) begin
      errors++;
      $display("FAIL stall_next: got %h/%h want 300c/3010",
               bus.if_pc, bus.imem_addr);
    end
  endtask

  task automatic test_branch(input bit with_wait);
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3014;
    exp_pc[1] = 32'h3100;
    exp_pc[2] = 32'h3104;
    do_reset();
    repeat (6) @(negedge clk);
    redir_valid = 1'b1;
    redir_pc    = 32'h3100;
    if (with_wait) r_ready = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== 32'h3014 || bus.if_pc !== 32'h3010) begin
      errors++;
      $display("FAIL br_slot: got %h/%h want 3014/3010",
               bus.imem_addr, bus.if_pc);
    end
    @(negedge clk);
    redir_valid = 1'b0;
    if (with_wait) begin
      #1;
      checks++;
      if (bus.imem_addr !== 32'h3014 || bus.if_valid !== 1'b0) begin
        errors++;
        $display("FAIL br_wait_hold: got %h/%b want 3014/0",
                 bus.imem_addr, bus.if_valid);
      end
      r_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.if_pc !== exp_pc[i] ||
          bus.imem_addr !== exp_pc[i] + 32'd4 * 32'(i == 0 ? 59 : 1)) begin
        errors++;
        $display("FAIL br_order: step %0d got %h/%h want if_pc %h",
                 i, bus.if_pc, bus.imem_addr, exp_pc[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pend();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3000;
    exp_pc[1] = 32'h3100;
    exp_pc[2] = 32'h3104;
    do_reset();
    redir_valid = 1'b1;
    redir_pc    = 32'h3100;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_gap: got %b/%b want 0/0",
               bus.imem_req, bus.if_valid);
    end
    @(negedge clk);
    redir_valid = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL pend_slot: got %b/%h want 1/3000",
               bus.imem_req, bus.imem_addr);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.if_pc !== exp_pc[i-1] || bus.imem_addr !== exp_pc[i]) begin
        errors++;
        $display("FAIL pend_order: step %0d got %h/%h want %h/%h",
                 i, bus.if_pc, bus.imem_addr, exp_pc[i-1], exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (9) @(negedge clk);
    r_ready = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== 32'h3020 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got %b/%h want 1/3020",
               bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    r_ready = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 ||
        bus.imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL mid_async: got %b/%b/%h want 0/0/3000",
               bus.imem_req, bus.if_valid, bus.imem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got %b want 0", bus.imem_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000 ||
        bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: got %b/%h/%b want 1/3000/0",
               bus.imem_req, bus.imem_addr, bus.if_valid);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    stall_d     = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    r_ready     = 1'b1;
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall();
    test_branch(1'b0);
    test_branch(1'b1);
    test_pend();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
